exec_sequencer: RTL

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exec_sequencer
// Purpose  : Instruction execution sequencer for a small multi-cycle core.
//            Steps each instruction through fetch, decode, unit dispatch,
//            unit completion and writeback. Interrupts are accepted only at
//            the instruction boundary. Illegal unit classes, and optionally
//            unit timeouts, stop the sequencer in a sticky TRAP state.
//
// Ports    : clk          in   core clock, rising edge active
//            rstn         in   asynchronous active-low reset
//            mem_done     in   memory transfer complete (1-cycle pulse)
//            dec_valid    in   decoder fields valid
//            unit_sel[2:0] in  unit class: 0 ALU, 1 LD/ST, 2 MUL, 3 BR/JMP,
//                              4 SYSTEM, 5-7 illegal
//            wb_req       in   instruction writes rd
//            unit_done[4:0] in per-unit done, indexed by unit_sel
//            irq_pending  in   level interrupt request
//            mem_en       out  memory request pulse
//            mem_is_fetch out  mem_en is an instruction fetch
//            dec_en       out  decoder enable
//            unit_en[4:0] out  one-hot unit start pulse
//            rd_we        out  register-file write strobe
//            pc_en        out  pc advance strobe
//            irq_take     out  interrupt accept pulse
//            trap         out  sticky halt flag
//            trap_cause[1:0] out 0 none, 1 illegal unit, 2 timeout
//            state[2:0]   out  current state encoding
//
// Options  : EXEC_SEQUENCER_TIMEOUT_EN - when defined, WAIT is bounded by
//            TIMEOUT_CYCLES and an expired wait traps with cause 2.
//
// Revision : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       mem_done,
   input  logic       dec_valid,
   input  logic [2:0] unit_sel,
   input  logic       wb_req,
   input  logic [4:0] unit_done,
   input  logic       irq_pending,
   output logic       mem_en,
   output logic       mem_is_fetch,
   output logic       dec_en,
   output logic [4:0] unit_en,
   output logic       rd_we,
   output logic       pc_en,
   output logic       irq_take,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      FWAIT  = 3'd2,
      DECODE = 3'd3,
      EXEC   = 3'd4,
      WAIT   = 3'd5,
      WB     = 3'd6,
      TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] c_cause_none    = 2'd0;
   localparam logic [1:0] c_cause_illegal = 2'd1;
   localparam logic [2:0] c_sel_last      = 3'd4;
   localparam logic [2:0] c_sel_ldst      = 3'd1;

   // Out-of-range limits are a build error rather than silent wraparound.
   generate
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
         $error("exec_sequencer: TIMEOUT_CYCLES must be within 1..255");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic       wb_q, wb_d;
   logic [1:0] cause_q, cause_d;

   logic       mem_en_q, mem_en_d;
   logic       mem_is_fetch_q, mem_is_fetch_d;
   logic       dec_en_q, dec_en_d;
   logic [4:0] unit_en_q, unit_en_d;
   logic       rd_we_q, rd_we_d;
   logic       pc_en_q, pc_en_d;
   logic       irq_take_q, irq_take_d;
   logic       trap_q, trap_d;

   // Done of the latched unit only; other units' done bits are masked off.
   logic [4:0] sel_onehot;
   logic       sel_done;

`ifdef EXEC_SEQUENCER_TIMEOUT_EN
   localparam logic [1:0] c_cause_timeout = 2'd2;
   // Counter holds the number of WAIT cycles already completed, so the
   // trap fires on the edge that ends WAIT cycle number TIMEOUT_CYCLES.
   localparam logic [7:0] c_timeout_last  = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      sel_onehot = 5'b00001 << sel_q;
      sel_done   = |(unit_done & sel_onehot);

      state_d = state_q;
      sel_d   = sel_q;
      wb_d    = wb_q;
      cause_d = cause_q;
`ifdef EXEC_SEQUENCER_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            // A mem_done seen here belongs to no request of ours; ignore it.
            state_d = FWAIT;
         end
         FWAIT: begin
            if (mem_done) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (dec_valid) begin
               if (unit_sel > c_sel_last) begin
                  state_d = TRAP;
                  cause_d = c_cause_illegal;
               end else begin
                  sel_d   = unit_sel;
                  wb_d    = wb_req;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            state_d = WAIT;
`ifdef EXEC_SEQUENCER_TIMEOUT_EN
            wait_cnt_d = 8'd0;
`endif
         end
         WAIT: begin
            // A done arriving on the final counted cycle still completes.
            if (sel_done) begin
               state_d = WB;
            end
`ifdef EXEC_SEQUENCER_TIMEOUT_EN
            else if (wait_cnt_q == c_timeout_last) begin
               state_d = TRAP;
               cause_d = c_cause_timeout;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end
         WB: begin
            state_d = FETCH;
         end
         TRAP: begin
            state_d = TRAP;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are a function of the state being entered so that, once
      // registered, each strobe lines up with the state it belongs to.
      mem_is_fetch_d = (state_d == FETCH);
      mem_en_d       = (state_d == FETCH) ||
                       ((state_d == EXEC) && (sel_d == c_sel_ldst));
      dec_en_d       = (state_d == DECODE);
      unit_en_d      = (state_d == EXEC) ? (5'b00001 << sel_d) : 5'b00000;
      rd_we_d        = (state_d == WB) && wb_d;
      pc_en_d        = (state_d == WB);
      // Interrupts are only sampled on the WB -> FETCH boundary.
      irq_take_d     = (state_q == WB) && irq_pending;
      trap_d         = (state_d == TRAP);
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         sel_q          <= 3'd0;
         wb_q           <= 1'b0;
         cause_q        <= c_cause_none;
         mem_en_q       <= 1'b0;
         mem_is_fetch_q <= 1'b0;
         dec_en_q       <= 1'b0;
         unit_en_q      <= 5'b00000;
         rd_we_q        <= 1'b0;
         pc_en_q        <= 1'b0;
         irq_take_q     <= 1'b0;
         trap_q         <= 1'b0;
`ifdef EXEC_SEQUENCER_TIMEOUT_EN
         wait_cnt_q     <= 8'd0;
`endif
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         wb_q           <= wb_d;
         cause_q        <= cause_d;
         mem_en_q       <= mem_en_d;
         mem_is_fetch_q <= mem_is_fetch_d;
         dec_en_q       <= dec_en_d;
         unit_en_q      <= unit_en_d;
         rd_we_q        <= rd_we_d;
         pc_en_q        <= pc_en_d;
         irq_take_q     <= irq_take_d;
         trap_q         <= trap_d;
`ifdef EXEC_SEQUENCER_TIMEOUT_EN
         wait_cnt_q     <= wait_cnt_d;
`endif
      end
   end

   assign mem_en       = mem_en_q;
   assign mem_is_fetch = mem_is_fetch_q;
   assign dec_en       = dec_en_q;
   assign unit_en      = unit_en_q;
   assign rd_we        = rd_we_q;
   assign pc_en        = pc_en_q;
   assign irq_take     = irq_take_q;
   assign trap         = trap_q;
   assign trap_cause   = cause_q;
   assign state        = state_q;

endmodule
`default_nettype wire
